sbox_cfg_ctrl: RTL and testbench

- Reconfiguration controller for the multi-dataflow switching network: owns the `sel` lines of all 1x2/2x1 sboxes in one datapath.
- On a configuration request it holds off the network source, drains in-flight tokens, waits a settle interval, then switches all `sel` bits atomically from a parameter lookup table.
- Sits between the host/config register block and the sbox instances; counts tokens at the network entry and exit points.

---
 rtl/sbox_ctrl_pkg.sv | 30 +++
 rtl/sbox_tok_cnt.sv | 23 ++
 rtl/sbox_cfg_ctrl.sv | 129 ++++++++++++
 tb/tb_sbox_cfg_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/sbox_ctrl_pkg.sv
// Shared types and helpers for the sbox reconfiguration controller.
package sbox_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_SWITCH = 2'd3
  } state_e;

  localparam logic [15:0] CFG_TABLE_DEF = 16'h9630;

  // Upper bounds for the generic table-extract helper.
  localparam int TBL_MAX = 1024;
  localparam int SEL_MAX = 32;

  function automatic logic [SEL_MAX-1:0] tbl_entry(input logic [TBL_MAX-1:0] tbl,
                                                   input int unsigned id,
                                                   input int unsigned n);
    logic [SEL_MAX-1:0] r;
    logic [9:0]         idx;
    r = '0;
    for (int unsigned b = 0; b < SEL_MAX; b++) begin
      idx = 10'(id * n + b);
      if (b < n && (id * n + b) < TBL_MAX) r[b] = tbl[idx];
    end
    return r;
  endfunction

endpackage

// File: rtl/sbox_tok_cnt.sv
// Saturating up/down count of tokens inside the switching network.
module sbox_tok_cnt #(
  parameter int CNT_W = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output logic is_zero
);

  logic [CNT_W-1:0] cnt;

  // Simultaneous inc/dec cancel; saturate high, never wrap below zero.
  always_ff @(posedge clock) begin
    if (reset)                              cnt <= '0;
    else if (inc && !dec && cnt != '1)      cnt <= cnt + CNT_W'(1);
    else if (dec && !inc && cnt != '0)      cnt <= cnt - CNT_W'(1);
  end

  assign is_zero = (cnt == '0);

endmodule

// File: rtl/sbox_cfg_ctrl.sv
// Drain/settle/switch controller for the sbox select lines.
// Optional drain timeout with abort: define SBOX_CTRL_TIMEOUT_EN.
module sbox_cfg_ctrl
  import sbox_ctrl_pkg::*;
#(
  parameter int                              NUM_SBOX    = 4,
  parameter int                              ID_W        = 2,
  parameter logic [(NUM_SBOX<<ID_W)-1:0]     CFG_TABLE   = CFG_TABLE_DEF,
  parameter int                              CNT_W       = 8,
  parameter int                              SETTLE_CYC  = 2,
  parameter int                              TIMEOUT_CYC = 1024
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cfg_req,
  input  logic [ID_W-1:0]     cfg_id,
  output logic                cfg_ack,
  output logic                cfg_err,
  output logic                cfg_busy,
  output logic [ID_W-1:0]     cur_id,
  output logic [NUM_SBOX-1:0] sel,
  input  logic                src_wr,
  input  logic                src_full_in,
  output logic                src_full_out,
  input  logic                snk_wr,
  input  logic                snk_full
);

  if (SETTLE_CYC < 1 || SETTLE_CYC > 15 || TIMEOUT_CYC < 1) begin : g_param_chk
    $error("sbox_cfg_ctrl: SETTLE_CYC must be 1..15 and TIMEOUT_CYC >= 1");
  end

  state_e            state, state_nxt;
  logic [ID_W-1:0]   tgt_id, tgt_nxt;
  logic [3:0]        settle_cnt, settle_nxt;
  logic              hold, is_zero, ack_nxt, sel_load, to_hit;

  assign hold         = (state == ST_DRAIN) || (state == ST_SETTLE);
  assign src_full_out = src_full_in | hold;
  assign cfg_busy     = (state != ST_IDLE);

  sbox_tok_cnt #(.CNT_W(CNT_W)) u_tok_cnt (
    .clock   (clock),
    .reset   (reset),
    .inc     (src_wr & ~src_full_out),
    .dec     (snk_wr & ~snk_full),
    .is_zero (is_zero)
  );

`ifdef SBOX_CTRL_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt;
  logic            err_q;

  // Counts every held cycle, including DRAIN<->SETTLE bounces.
  assign to_hit = hold && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      to_cnt <= hold ? to_cnt + TO_W'(1) : '0;
      err_q  <= to_hit;
    end
  end
  assign cfg_err = err_q;
`else
  assign to_hit  = 1'b0;
  assign cfg_err = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    tgt_nxt    = tgt_id;
    settle_nxt = settle_cnt;
    ack_nxt    = 1'b0;
    sel_load   = 1'b0;
    case (state)
      ST_IDLE: if (cfg_req) begin
        tgt_nxt = cfg_id;
        if (cfg_id == cur_id) ack_nxt   = 1'b1;
        else                  state_nxt = ST_DRAIN;
      end
      ST_DRAIN: if (is_zero) begin
        state_nxt  = ST_SETTLE;
        settle_nxt = '0;
      end
      ST_SETTLE: begin
        if (!is_zero)                               state_nxt  = ST_DRAIN;
        else if (settle_cnt == 4'(SETTLE_CYC - 1))  state_nxt  = ST_SWITCH;
        else                                        settle_nxt = settle_cnt + 4'd1;
      end
      ST_SWITCH: begin
        state_nxt = ST_IDLE;
        ack_nxt   = 1'b1;
        sel_load  = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Abort wins over a switch scheduled in the same cycle.
    if (to_hit) begin
      state_nxt = ST_IDLE;
      ack_nxt   = 1'b1;
      sel_load  = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      tgt_id     <= '0;
      settle_cnt <= '0;
      cfg_ack    <= 1'b0;
      cur_id     <= '0;
      sel        <= NUM_SBOX'(tbl_entry(TBL_MAX'(CFG_TABLE), 32'd0, NUM_SBOX));
    end else begin
      state      <= state_nxt;
      tgt_id     <= tgt_nxt;
      settle_cnt <= settle_nxt;
      cfg_ack    <= ack_nxt;
      if (sel_load) begin
        sel    <= NUM_SBOX'(tbl_entry(TBL_MAX'(CFG_TABLE), 32'(tgt_id), NUM_SBOX));
        cur_id <= tgt_id;
      end
    end
  end

endmodule

// File: tb/tb_sbox_cfg_ctrl.sv
// Self-checking bench for sbox_cfg_ctrl: directed cases plus randomized traffic vs. a behavioural model.
module tb_sbox_cfg_ctrl;

  localparam int NUM_SBOX    = 4;
  localparam int ID_W        = 2;
  localparam int CNT_W       = 8;
  localparam int SETTLE_CYC  = 2;
  localparam int TIMEOUT_CYC = 16;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;
`ifdef SBOX_CTRL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic                cfg_req = 1'b0;
  logic [ID_W-1:0]     cfg_id = '0;
  logic                src_wr = 1'b0, src_full_in = 1'b0, snk_wr = 1'b0, snk_full = 1'b0;
  logic                cfg_ack, cfg_err, cfg_busy, src_full_out;
  logic [ID_W-1:0]     cur_id;
  logic [NUM_SBOX-1:0] sel;

  int n_chk  = 0;
  int n_fail = 0;
  int sel_tbl[4] = '{0, 3, 6, 9};

  always #5 clock = ~clock;

  sbox_cfg_ctrl #(
    .NUM_SBOX(NUM_SBOX), .ID_W(ID_W), .CFG_TABLE(16'h9630), .CNT_W(CNT_W),
    .SETTLE_CYC(SETTLE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clock(clock), .reset(reset), .cfg_req(cfg_req), .cfg_id(cfg_id),
    .cfg_ack(cfg_ack), .cfg_err(cfg_err), .cfg_busy(cfg_busy), .cur_id(cur_id), .sel(sel),
    .src_wr(src_wr), .src_full_in(src_full_in), .src_full_out(src_full_out),
    .snk_wr(snk_wr), .snk_full(snk_full)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: tokens in flight, pending target, run of quiet held cycles, age of the hold.
  int m_tok, m_tgt, m_cur, m_quiet, m_age;
  bit m_pend, m_due, m_ack, m_err;

  always @(posedge clock) begin : model
    int tok, tgt, cur, quiet, age;
    bit pend, due, ack, err, h, acc_in, acc_out;
    if (reset) begin
      m_tok <= 0; m_tgt <= 0; m_cur <= 0; m_quiet <= 0; m_age <= 0;
      m_pend <= 0; m_due <= 0; m_ack <= 0; m_err <= 0;
    end else begin
      tok = m_tok; tgt = m_tgt; cur = m_cur; quiet = m_quiet; age = m_age;
      pend = m_pend; due = m_due; ack = 0; err = 0;
      h       = m_pend && !m_due;
      acc_in  = src_wr && !(src_full_in || h);
      acc_out = snk_wr && !snk_full;
      if (acc_in && !acc_out)                 tok = (m_tok == CNT_MAX) ? CNT_MAX : m_tok + 1;
      else if (acc_out && !acc_in && m_tok > 0) tok = m_tok - 1;
      if (!m_pend) begin
        if (cfg_req) begin
          if (int'(cfg_id) == m_cur) ack = 1;
          else begin pend = 1; tgt = int'(cfg_id); quiet = 0; age = 0; end
        end
      end else if (m_due) begin
        cur = m_tgt; ack = 1; pend = 0; due = 0;
      end else begin
        // Switch needs one drained cycle plus SETTLE_CYC quiet cycles in a row.
        age   = m_age + 1;
        quiet = (m_tok == 0) ? m_quiet + 1 : 0;
        if (TO_EN && age == TIMEOUT_CYC) begin pend = 0; ack = 1; err = 1; end
        else if (quiet == SETTLE_CYC + 1) due = 1;
      end
      m_tok <= tok; m_tgt <= tgt; m_cur <= cur; m_quiet <= quiet; m_age <= age;
      m_pend <= pend; m_due <= due; m_ack <= ack; m_err <= err;
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      chk("sel",          int'(sel),          sel_tbl[m_cur]);
      chk("cur_id",       int'(cur_id),       m_cur);
      chk("cfg_ack",      int'(cfg_ack),      int'(m_ack));
      chk("cfg_err",      int'(cfg_err),      int'(m_err));
      chk("cfg_busy",     int'(cfg_busy),     int'(m_pend));
      chk("src_full_out", int'(src_full_out), int'(src_full_in || (m_pend && !m_due)));
    end
  end

  // Called at posedge+1: one-cycle request pulse.
  task automatic req(input int id);
    cfg_req = 1'b1;
    cfg_id  = ID_W'(id);
    @(posedge clock); #1;
    cfg_req = 1'b0;
  endtask

  task automatic wait_ack(input int snk_per, input bit src_on, input int inj,
                          output int lat, output int holds, output int err);
    lat = 0; holds = 0; err = 0;
    for (int i = 1; i <= 60; i++) begin
      snk_wr = (snk_per > 0) && (i % snk_per == snk_per - 1);
      src_wr = src_on || (i == inj);
      @(negedge clock);
      if (src_full_out) holds++;
      if (cfg_ack) begin lat = i; err = int'(cfg_err); break; end
      @(posedge clock); #1;
    end
    @(posedge clock); #1;
    snk_wr = 1'b0; src_wr = 1'b0;
  endtask

  task automatic drain();
    snk_full = 1'b0; snk_wr = 1'b1; src_wr = 1'b0;
    repeat (8) @(posedge clock);
    #1 snk_wr = 1'b0;
  endtask

  initial begin
    int lat, holds, err;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_sel", int'(sel), 0);
    chk("rst_cur_id", int'(cur_id), 0);
    chk("rst_busy", int'(cfg_busy), 0);
    chk("rst_ack", int'(cfg_ack), 0);
    #1 src_full_in = 1'b1;
    #1 chk("full_follow_hi", int'(src_full_out), 1);
    src_full_in = 1'b0;
    #1 chk("full_follow_lo", int'(src_full_out), 0);
    @(posedge clock); #1;

    // Empty network switch to id 2.
    req(2);
    wait_ack(0, 1'b0, 0, lat, holds, err);
    chk("empty_lat", lat, 5);
    chk("empty_holds", holds, 3);
    chk("empty_sel", int'(sel), 6);
    chk("empty_cur", int'(cur_id), 2);
    chk("empty_err", err, 0);

    // Same id: immediate ack, no hold.
    req(2);
    wait_ack(0, 1'b0, 0, lat, holds, err);
    chk("same_lat", lat, 1);
    chk("same_holds", holds, 0);
    chk("same_sel", int'(sel), 6);

    // Three tokens in flight, sink drains one per 4 cycles, source keeps trying.
    src_wr = 1'b1;
    repeat (3) @(posedge clock);
    #1 src_wr = 1'b0;
    req(1);
    wait_ack(4, 1'b1, 0, lat, holds, err);
    chk("tok_lat", lat, 16);
    chk("tok_holds", holds, 14);
    chk("tok_sel", int'(sel), 3);
    chk("tok_cur", int'(cur_id), 1);
    drain();

    // Source write during SETTLE must be blocked by hold.
    @(posedge clock); #1;
    req(0);
    wait_ack(0, 1'b0, 2, lat, holds, err);
    chk("settle_inj_lat", lat, 5);
    chk("settle_inj_sel", int'(sel), 0);

`ifdef SBOX_CTRL_TIMEOUT_EN
    src_wr = 1'b1;
    @(posedge clock); #1 src_wr = 1'b0;
    snk_full = 1'b1;
    req(3);
    wait_ack(1, 1'b0, 0, lat, holds, err);
    chk("to_lat", lat, TIMEOUT_CYC + 1);
    chk("to_err", err, 1);
    chk("to_sel", int'(sel), 0);
    chk("to_busy", int'(cfg_busy), 0);
    drain();
`endif

    // Switch to id 3, then reset in the middle of the next request.
    req(3);
    wait_ack(0, 1'b0, 0, lat, holds, err);
    chk("pre_rst_sel", int'(sel), 9);
    req(1);
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    chk("midrst_sel", int'(sel), 0);
    chk("midrst_cur", int'(cur_id), 0);
    chk("midrst_busy", int'(cfg_busy), 0);
    @(posedge clock); #1;

    // Random traffic, a saturating burst, then random traffic biased to drain.
    for (int i = 0; i < 1500; i++) begin
      src_wr = $urandom_range(1, 0); src_full_in = ($urandom_range(3, 0) == 0);
      snk_wr = $urandom_range(1, 0); snk_full    = ($urandom_range(3, 0) == 0);
      cfg_req = ($urandom_range(7, 0) == 0); cfg_id = ID_W'($urandom_range(3, 0));
      @(posedge clock); #1;
    end
    cfg_req = 1'b0; src_full_in = 1'b0; snk_wr = 1'b0; src_wr = 1'b1;
    repeat (300) @(posedge clock);
    #1;
    for (int i = 0; i < 2000; i++) begin
      src_wr = ($urandom_range(3, 0) == 0); src_full_in = ($urandom_range(3, 0) == 0);
      snk_wr = ($urandom_range(3, 0) != 0); snk_full    = ($urandom_range(7, 0) == 0);
      cfg_req = ($urandom_range(15, 0) == 0); cfg_id = ID_W'($urandom_range(3, 0));
      @(posedge clock); #1;
    end
    cfg_req = 1'b0; src_wr = 1'b0; snk_wr = 1'b0;
    repeat (4) @(posedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
